// File: rtl/tokens_pkg.sv
// tokens_pkg: DDP result token layout, receiver states and field helpers
package tokens_pkg;
    localparam int TOKEN_W = 62;
    localparam int LR_BIT = 61;
    localparam int UNI_BIT = 60;
    localparam int MEMW_HI = 59;
    localparam int MEMW_LO = 58;
    localparam int NODE_HI = 57;
    localparam int NODE_LO = 44;
    localparam int GEN_HI = 43;
    localparam int GEN_LO = 32;
    localparam int OPR_HI = 31;
    localparam int OPR_LO = 0;
    typedef logic [TOKEN_W-1:0] token_t;
    typedef enum logic [1:0] {IDLE, RECV, DONE} rx_state_t;
    function automatic logic get_lr(input token_t t);
        return t[LR_BIT];
    endfunction
    function automatic logic get_uni(input token_t t);
        return t[UNI_BIT];
    endfunction
    function automatic logic [1:0] get_memw(input token_t t);
        return t[MEMW_HI:MEMW_LO];
    endfunction
    function automatic logic [13:0] get_node(input token_t t);
        return t[NODE_HI:NODE_LO];
    endfunction
    function automatic logic [11:0] get_gen(input token_t t);
        return t[GEN_HI:GEN_LO];
    endfunction
    function automatic logic [31:0] get_opr(input token_t t);
        return t[OPR_HI:OPR_LO];
    endfunction
endpackage

// File: rtl/token_fifo.sv
// token_fifo: synchronous first-word-fall-through FIFO, DEPTH a power of two
module token_fifo #(
    parameter int W = 62,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         rd_en,
    output logic [W-1:0] dout,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic wr_ok, rd_ok;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign dout = empty ? '0 : mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp[AW-1:0]] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/token_receiver.sv
// token_receiver: 2-phase DDP token sink with FIFO, token count and opr sum
module token_receiver #(
    parameter int TOKEN_W = 62,
    parameter int FIFO_DEPTH = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               send_i_tr,
    input  logic [TOKEN_W-1:0] token_i_tr,
    output logic               ack_o_tr,
    input  logic               start_i_tr,
    input  logic [CNT_W-1:0]   expect_num_i_tr,
    input  logic               rd_en_i_tr,
    output logic [TOKEN_W-1:0] token_o_tr,
    output logic               valid_o_tr,
    output logic [CNT_W-1:0]   count_o_tr,
    output logic [31:0]        opr_sum_o_tr,
    output logic               recv_done_o_tr,
    output logic               extra_o_tr
);
    import tokens_pkg::*;
    rx_state_t state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0] expect_q, count_inc;
    logic send_s, pending, full, empty, accept;
    assign send_s = sync[SYNC_STAGES-1];
    assign pending = send_s ^ ack_o_tr;
    assign accept = pending && state != IDLE && !full;
    assign count_inc = &count_o_tr ? count_o_tr : count_o_tr + 1'b1;
    assign valid_o_tr = !empty;
    assign recv_done_o_tr = state == DONE;
    // The registered count check also finishes a zero-length run one cycle after start.
    always_comb begin
        state_n = start_i_tr ? RECV
                : (state == RECV && ((accept && count_inc == expect_q) || count_o_tr == expect_q)) ? DONE
                : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sync <= '0;
            ack_o_tr <= 1'b0;
            count_o_tr <= '0;
            opr_sum_o_tr <= '0;
            extra_o_tr <= 1'b0;
            expect_q <= '0;
        end else begin
            state <= state_n;
            sync <= {sync[SYNC_STAGES-2:0], send_i_tr};
            if (accept) ack_o_tr <= ~ack_o_tr;
            if (start_i_tr) begin
                count_o_tr <= '0;
                opr_sum_o_tr <= '0;
                extra_o_tr <= 1'b0;
                expect_q <= expect_num_i_tr;
            end else if (accept) begin
                count_o_tr <= count_inc;
                opr_sum_o_tr <= opr_sum_o_tr + get_opr(token_i_tr);
                if (state == DONE) extra_o_tr <= 1'b1;
            end
        end
    end
    token_fifo #(.W(TOKEN_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_en(accept),
        .din(token_i_tr),
        .full(full),
        .rd_en(rd_en_i_tr),
        .dout(token_o_tr),
        .empty(empty)
    );
endmodule
